// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: field-level request bus in, encoded imem write bus out
interface instr_encoder_loader_if #(parameter int ADDR_W = 10);
  logic req_valid;
  logic req_ready;
  logic [2:0] req_fmt;
  logic [6:0] req_opcode;
  logic [4:0] req_rd;
  logic [4:0] req_rs1;
  logic [4:0] req_rs2;
  logic [2:0] req_funct3;
  logic [6:0] req_funct7;
  logic [31:0] req_imm;
  logic imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  modport master (
    output req_valid, req_fmt, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    input req_ready, imem_we, imem_addr, imem_wdata
  );
  modport slave (
    input req_valid, req_fmt, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes RV32 field requests into words, buffers them and streams them into imem
module instr_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int unsigned BASE_ADDR = 0
) (
  input logic clk,
  input logic rst,
  instr_encoder_loader_if.slave bus,
  input logic start,
  input logic finish,
  input logic clr_err,
  output logic done,
  output logic err,
  output logic wrapped
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [PW:0] wptr_q, rptr_q;
  logic [ADDR_W-1:0] cnt_q, addr_q;
  logic [31:0] wdata_q, word, imm;
  logic we_q, err_q, wrapped_q;
  logic full, empty, accept, illegal, push, pop, restart;
  assign imm = bus.req_imm;
  assign full = (wptr_q - rptr_q) == (PW+1)'(FIFO_DEPTH);
  assign empty = wptr_q == rptr_q;
  assign bus.req_ready = (state_q == IDLE || state_q == RUN) && !full;
  assign accept = bus.req_valid && bus.req_ready;
  assign illegal = bus.req_fmt > 3'd5 || ((bus.req_fmt == 3'd3 || bus.req_fmt == 3'd5) && imm[0]);
  assign push = accept && !illegal;
  assign pop = (state_q == RUN || state_q == DRAIN) && !empty;
  assign restart = (state_q == IDLE || state_q == DONE) && start;
  assign word =
    bus.req_fmt == 3'd0 ? {bus.req_funct7, bus.req_rs2, bus.req_rs1, bus.req_funct3, bus.req_rd, bus.req_opcode} :
    bus.req_fmt == 3'd1 ? {imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, bus.req_opcode} :
    bus.req_fmt == 3'd2 ? {imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3, imm[4:0], bus.req_opcode} :
    bus.req_fmt == 3'd3 ? {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, bus.req_funct3, imm[4:1], imm[11], bus.req_opcode} :
    bus.req_fmt == 3'd4 ? {imm[31:12], bus.req_rd, bus.req_opcode} :
                          {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, bus.req_opcode};
  always_comb begin
    state_d = restart ? RUN :
              (state_q == RUN && finish) ? DRAIN :
              (state_q == DRAIN && empty) ? DONE : state_q;
  end
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q[PW-1:0]] <= word;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= ADDR_W'(BASE_ADDR);
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= pop;
      err_q <= (err_q && !clr_err) || (accept && illegal);
      if (push)
        wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        addr_q <= cnt_q;
        wdata_q <= mem_q[rptr_q[PW-1:0]];
        cnt_q <= cnt_q + 1'b1;
        if (&cnt_q)
          wrapped_q <= 1'b1;
      end
      if (restart) begin
        cnt_q <= ADDR_W'(BASE_ADDR);
        wrapped_q <= 1'b0;
      end
    end
  end
  assign bus.imem_we = we_q;
  assign bus.imem_addr = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign done = state_q == DONE;
  assign err = err_q;
  assign wrapped = wrapped_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed and randomized checks of instr_encoder_loader against a behavioural model
module tb_instr_encoder_loader;
  localparam int AW = 4;
  localparam int DEPTH = 4;
  typedef struct {int c; logic [AW-1:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic finish = 1'b0;
  logic clr_err = 1'b0;
  logic done, err, wrapped;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  wr_t log_q[$];
  logic [31:0] q[$];
  bit m_run, m_drain, m_fin, m_err, m_wrapped, m_we, armed;
  bit m_acc, m_bad, m_pop, m_empty0;
  int unsigned m_cnt;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata;
  instr_encoder_loader_if #(.ADDR_W(AW)) bus ();
  instr_encoder_loader #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .start(start), .finish(finish), .clr_err(clr_err),
    .done(done), .err(err), .wrapped(wrapped)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] enc(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] base;
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (fmt)
      3'd0: return (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
      3'd1: return ((imm & 32'hfff) << 20) | base | (32'(rd) << 7);
      3'd2: return (((imm >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1f) << 7);
      3'd3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (32'(rs2) << 20) | base |
                   (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7);
      3'd4: return (imm & 32'hfffff000) | (32'(rd) << 7) | 32'(op);
      3'd5: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21) | (((imm >> 11) & 1) << 20) |
                   (imm & 32'h000ff000) | (32'(rd) << 7) | 32'(op);
      default: return 32'h0;
    endcase
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // Reference model: one step per rising edge, from the accepted-request and start/finish rules.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_run = 0;
      m_drain = 0;
      m_fin = 0;
      m_err = 0;
      m_wrapped = 0;
      m_we = 0;
      m_cnt = 0;
      m_addr = '0;
      m_wdata = '0;
      armed = 1;
    end else begin
      m_empty0 = q.size() == 0;
      m_acc = bus.req_valid && !m_drain && !m_fin && q.size() < DEPTH;
      m_bad = bus.req_fmt > 5 || ((bus.req_fmt == 3 || bus.req_fmt == 5) && bus.req_imm[0]);
      m_pop = (m_run || m_drain) && !m_empty0;
      m_we = m_pop;
      if (m_pop) begin
        m_addr = AW'(m_cnt);
        m_wdata = q.pop_front();
        if (m_cnt == 2**AW - 1) m_wrapped = 1;
        m_cnt = (m_cnt + 1) % (2**AW);
      end
      if (m_acc && !m_bad)
        q.push_back(enc(bus.req_fmt, bus.req_opcode, bus.req_rd, bus.req_rs1, bus.req_rs2,
                        bus.req_funct3, bus.req_funct7, bus.req_imm));
      m_err = (m_err && !clr_err) || (m_acc && m_bad);
      if (!m_run && !m_drain && start) begin
        m_run = 1;
        m_fin = 0;
        m_cnt = 0;
        m_wrapped = 0;
      end else if (m_run && finish) begin
        m_run = 0;
        m_drain = 1;
      end else if (m_drain && m_empty0) begin
        m_drain = 0;
        m_fin = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      check("imem_we", 32'(bus.imem_we), 32'(m_we));
      check("imem_addr", 32'(bus.imem_addr), 32'(m_addr));
      check("imem_wdata", bus.imem_wdata, m_wdata);
      check("req_ready", 32'(bus.req_ready), 32'(!m_drain && !m_fin && q.size() < DEPTH));
      check("done", 32'(done), 32'(m_fin));
      check("err", 32'(err), 32'(m_err));
      check("wrapped", 32'(wrapped), 32'(m_wrapped));
      if (bus.imem_we === 1'b1) log_q.push_back('{cyc, bus.imem_addr, bus.imem_wdata});
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    log_q.delete();
  endtask
  task automatic pulse(input int which);
    if (which == 0) start = 1'b1;
    if (which == 1) finish = 1'b1;
    if (which == 2) clr_err = 1'b1;
    tick(1);
    start = 1'b0;
    finish = 1'b0;
    clr_err = 1'b0;
  endtask
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    int k = 0;
    bus.req_valid = 1'b1;
    bus.req_fmt = fmt;
    bus.req_opcode = op;
    bus.req_rd = rd;
    bus.req_rs1 = rs1;
    bus.req_rs2 = rs2;
    bus.req_funct3 = f3;
    bus.req_funct7 = f7;
    bus.req_imm = imm;
    while (bus.req_ready !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    if (k == 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: req_ready stayed %b, required 1 within 50 cycles", bus.req_ready);
    end
    tick(1);
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 100) begin
      tick(1);
      k++;
    end
    check("done_reached", 32'(done), 32'h1);
  endtask
  task automatic check_log(input string name, input int idx, input logic [AW-1:0] a, input logic [31:0] d);
    if (idx >= log_q.size()) check({name, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
    else begin
      check({name, "_addr"}, 32'(log_q[idx].a), 32'(a));
      check({name, "_data"}, log_q[idx].d, d);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int base_n;
    bus.req_valid = 1'b0;
    bus.req_fmt = '0;
    bus.req_opcode = '0;
    bus.req_rd = '0;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    bus.req_funct3 = '0;
    bus.req_funct7 = '0;
    bus.req_imm = '0;
    check("enc_addi", enc(1, 7'h13, 1, 0, 0, 0, 0, 5), 32'h00500093);
    check("enc_add", enc(0, 7'h33, 3, 1, 2, 0, 7'h00, 0), 32'h002081B3);
    check("enc_sub", enc(0, 7'h33, 3, 1, 2, 0, 7'h20, 0), 32'h402081B3);
    check("enc_sw", enc(2, 7'h23, 0, 1, 2, 2, 0, 8), 32'h0020A423);
    check("enc_beq", enc(3, 7'h63, 0, 1, 2, 0, 0, 8), 32'h00208463);
    check("enc_jal", enc(5, 7'h6F, 1, 0, 0, 0, 0, 16), 32'h010000EF);
    check("enc_lui", enc(4, 7'h37, 5, 0, 0, 0, 0, 32'h12345000), 32'h123452B7);
    tick(2);
    rst = 1'b0;
    check("rst_ready", 32'(bus.req_ready), 32'h1);
    check("rst_we", 32'(bus.imem_we), 32'h0);
    check("rst_addr", 32'(bus.imem_addr), 32'h0);
    check("rst_flags", {29'h0, done, err, wrapped}, 32'h0);
    send(1, 7'h13, 1, 0, 0, 0, 0, 5);
    pulse(0);
    tick(5);
    check("t1_writes", 32'(log_q.size()), 32'h1);
    check_log("t1", 0, 0, 32'h00500093);
    do_reset();
    send(0, 7'h33, 3, 1, 2, 0, 7'h00, 0);
    send(0, 7'h33, 3, 1, 2, 0, 7'h20, 0);
    pulse(0);
    pulse(1);
    wait_done();
    check_log("t2_add", 0, 0, 32'h002081B3);
    check_log("t2_sub", 1, 1, 32'h402081B3);
    pulse(0);
    send(2, 7'h23, 0, 1, 2, 2, 0, 8);
    send(3, 7'h63, 0, 1, 2, 0, 0, 8);
    send(5, 7'h6F, 1, 0, 0, 0, 0, 16);
    send(4, 7'h37, 5, 0, 0, 0, 0, 32'h12345000);
    pulse(1);
    wait_done();
    check_log("t3_sw", 2, 0, 32'h0020A423);
    check_log("t3_beq", 3, 1, 32'h00208463);
    check_log("t3_jal", 4, 2, 32'h010000EF);
    check_log("t3_lui", 5, 3, 32'h123452B7);
    do_reset();
    for (int i = 0; i < 4; i++) send(1, 7'h13, 5'(i + 1), 0, 0, 0, 0, 32'(i));
    check("t4_full_ready", 32'(bus.req_ready), 32'h0);
    pulse(0);
    tick(8);
    check("t4_writes", 32'(log_q.size()), 32'h4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      check_log("t4", i, AW'(i), enc(1, 7'h13, 5'(i + 1), 0, 0, 0, 0, 32'(i)));
      check("t4_b2b", 32'(log_q[i].c - log_q[0].c), 32'(i));
    end
    do_reset();
    pulse(0);
    send(6, 7'h13, 1, 0, 0, 0, 0, 5);
    send(3, 7'h63, 0, 1, 2, 0, 0, 7);
    tick(4);
    check("t5_writes", 32'(log_q.size()), 32'h0);
    check("t5_err", 32'(err), 32'h1);
    pulse(2);
    check("t5_clr", 32'(err), 32'h0);
    do_reset();
    pulse(0);
    for (int i = 0; i < 2**AW + 1; i++) send(1, 7'h13, 2, 0, 0, 0, 0, 32'(i));
    tick(6);
    check("t6_writes", 32'(log_q.size()), 32'(2**AW + 1));
    check_log("t6_wrap", 2**AW, 0, enc(1, 7'h13, 2, 0, 0, 0, 0, 32'(2**AW)));
    check("t6_wrapped", 32'(wrapped), 32'h1);
    do_reset();
    for (int i = 0; i < 3; i++) send(1, 7'h13, 3, 0, 0, 0, 0, 32'(i));
    pulse(0);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_we", 32'(bus.imem_we), 32'h0);
    check("t6_rst_ready", 32'(bus.req_ready), 32'h1);
    base_n = log_q.size();
    pulse(0);
    tick(5);
    check("t6_rst_flushed", 32'(log_q.size()), 32'(base_n));
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.req_valid = $urandom_range(0, 2) != 0;
      bus.req_fmt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      bus.req_opcode = 7'($urandom);
      bus.req_rd = 5'($urandom);
      bus.req_rs1 = 5'($urandom);
      bus.req_rs2 = 5'($urandom);
      bus.req_funct3 = 3'($urandom);
      bus.req_funct7 = 7'($urandom);
      bus.req_imm = $urandom;
      if ($urandom_range(0, 7) != 0) bus.req_imm[0] = 1'b0;
      start = $urandom_range(0, 15) == 0;
      finish = $urandom_range(0, 40) == 0;
      clr_err = $urandom_range(0, 30) == 0;
      rst = $urandom_range(0, 400) == 0;
      tick(1);
    end
    bus.req_valid = 1'b0;
    start = 1'b0;
    finish = 1'b0;
    clr_err = 1'b0;
    rst = 1'b0;
    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
